// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and the result record passed over the
// common data bus.
//   DATA_W / TAG_W / REG_W : widths of value, producer tag and dest register
//   TAG_*                  : reservation-station tags of the two producers
//   result_t               : {value, src, dreg, nowb}
package cdb_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int REG_W  = 4;

  localparam logic [TAG_W-1:0] TAG_ADD0 = 4'd0;
  localparam logic [TAG_W-1:0] TAG_ADD1 = 4'd1;
  localparam logic [TAG_W-1:0] TAG_LD0  = 4'd2;
  localparam logic [TAG_W-1:0] TAG_LD1  = 4'd3;
  localparam logic [TAG_W-1:0] TAG_NONE = 4'hF;

  // nowb marks a jeq outcome: broadcast for tag wakeup, but no register writeback.
  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  src;
    logic [REG_W-1:0]  dreg;
    logic              nowb;
  } result_t;

endpackage

// File: rtl/cdb_hold_buf.sv
// cdb_hold_buf: one-entry buffer holding a result that lost arbitration.
//   clk, rst : clock, synchronous active-high clear
//   load     : capture dIn and mark full
//   drain    : entry was broadcast; mark empty
//   dIn      : result to capture
//   full     : entry valid
//   q        : buffered result
// load and drain are never asserted together: a side only loads while its
// buffer is empty (ready is the inverse of full).
module cdb_hold_buf
  import cdb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    drain,
  input  result_t dIn,
  output logic    full,
  output result_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= dIn;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates the single common data bus between the adder unit
// and the loader unit, and broadcasts the winner on registered outputs.
//   clk, rst                  : clock, synchronous active-high reset
//   f_valid/f_ready/f_*       : adder result handshake and payload (f_nowb = jeq)
//   l_valid/l_ready/l_*       : loader result handshake and payload
//   cdb_valid/value/src/reg   : registered bus broadcast
//   cdb_wb                    : consumers may write back (0 for jeq outcome)
//   cdb_from_load             : winner was the loader
//   busy_cnt                  : cycles the bus carries a result (wraps)
//   conflict_cnt              : cycles both sides competed (saturates)
//
// Handshake: a producer holds *_valid and its payload stable until the cycle
// where *_valid && *_ready; the result is taken on that posedge. *_ready is
// registered-only (!hold buffer full), so it never depends on *_valid.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [DATA_W-1:0] f_value,
  input  logic [TAG_W-1:0]  f_src,
  input  logic [REG_W-1:0]  f_reg,
  input  logic              f_nowb,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [DATA_W-1:0] l_value,
  input  logic [TAG_W-1:0]  l_src,
  input  logic [REG_W-1:0]  l_reg,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_value,
  output logic [TAG_W-1:0]  cdb_src,
  output logic [REG_W-1:0]  cdb_reg,
  output logic              cdb_wb,
  output logic              cdb_from_load,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  result_t fIn, lIn, fBufQ, lBufQ, fCand, lCand, winner;
  logic    fFull, lFull, fAcc, lAcc, fHas, lHas, bothHas, pickLoad;
  logic    fLoad, fDrain, lLoad, lDrain;
  logic    rr;  // 0: adder wins the next conflict, 1: loader wins

  assign fIn = '{value: f_value, src: f_src, dreg: f_reg, nowb: f_nowb};
  assign lIn = '{value: l_value, src: l_src, dreg: l_reg, nowb: 1'b0};

  assign f_ready = !fFull;
  assign l_ready = !lFull;

  assign fAcc = f_valid && !fFull;
  assign lAcc = l_valid && !lFull;

  // A buffered result always outranks new input on its side (new input is
  // blocked anyway while the buffer is full).
  assign fHas  = fFull || fAcc;
  assign lHas  = lFull || lAcc;
  assign fCand = fFull ? fBufQ : fIn;
  assign lCand = lFull ? lBufQ : lIn;

  assign bothHas  = fHas && lHas;
  assign pickLoad = lHas && (!fHas || rr);
  assign winner   = pickLoad ? lCand : fCand;

  // Only an incoming loser needs capturing; a buffered loser just stays.
  assign fLoad  = bothHas && pickLoad && fAcc;
  assign lLoad  = bothHas && !pickLoad && lAcc;
  assign fDrain = fFull && !pickLoad;
  assign lDrain = lFull && pickLoad;

  cdb_hold_buf u_fBuf (
    .clk   (clk),
    .rst   (rst),
    .load  (fLoad),
    .drain (fDrain),
    .dIn   (fIn),
    .full  (fFull),
    .q     (fBufQ)
  );

  cdb_hold_buf u_lBuf (
    .clk   (clk),
    .rst   (rst),
    .load  (lLoad),
    .drain (lDrain),
    .dIn   (lIn),
    .full  (lFull),
    .q     (lBufQ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid     <= 1'b0;
      cdb_value     <= '0;
      cdb_src       <= '0;
      cdb_reg       <= '0;
      cdb_wb        <= 1'b0;
      cdb_from_load <= 1'b0;
      rr            <= 1'b0;
      busy_cnt      <= '0;
      conflict_cnt  <= '0;
    end else begin
      cdb_valid <= fHas || lHas;
      if (fHas || lHas) begin
        cdb_value     <= winner.value;
        cdb_src       <= winner.src;
        cdb_reg       <= winner.dreg;
        // loader candidates always carry nowb=0, so this is !(adder && nowb)
        cdb_wb        <= !winner.nowb;
        cdb_from_load <= pickLoad;
        busy_cnt      <= busy_cnt + 1'b1;
      end
      if (bothHas) begin
        // hand priority to the side that just lost
        rr <= !pickLoad;
        if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of the CDB arbiter against a
// queue-based reference model. Counters use a narrow width so wrap and
// saturation are reached within the run.
module tb_cdb_arbiter;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_valid, f_ready, f_nowb;
  logic [15:0]   f_value;
  logic [3:0]    f_src, f_reg;
  logic          l_valid, l_ready;
  logic [15:0]   l_value;
  logic [3:0]    l_src, l_reg;
  logic          cdb_valid, cdb_wb, cdb_from_load;
  logic [15:0]   cdb_value;
  logic [3:0]    cdb_src, cdb_reg;
  logic [CW-1:0] busy_cnt, conflict_cnt;

  cdb_arbiter #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .f_valid       (f_valid),
    .f_ready       (f_ready),
    .f_value       (f_value),
    .f_src         (f_src),
    .f_reg         (f_reg),
    .f_nowb        (f_nowb),
    .l_valid       (l_valid),
    .l_ready       (l_ready),
    .l_value       (l_value),
    .l_src         (l_src),
    .l_reg         (l_reg),
    .cdb_valid     (cdb_valid),
    .cdb_value     (cdb_value),
    .cdb_src       (cdb_src),
    .cdb_reg       (cdb_reg),
    .cdb_wb        (cdb_wb),
    .cdb_from_load (cdb_from_load),
    .busy_cnt      (busy_cnt),
    .conflict_cnt  (conflict_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each side keeps a list of results accepted but not yet broadcast. Every
  // cycle at most one is broadcast; on a tie the round-robin pointer decides
  // and then points at the loser.
  typedef struct {
    logic [15:0] value;
    logic [3:0]  src;
    logic [3:0]  rg;
    logic        nowb;
  } item_t;

  item_t           fq[$];
  item_t           lq[$];
  logic [28:0]     exp_q[$];     // {valid, f_ready, l_ready, wb, from_load, value, src, reg}
  logic [2*CW-1:0] cnt_q[$];     // {busy, conflict}
  bit              m_rr   = 1'b0;
  int              m_busy = 0;
  int              m_conf = 0;

  always @(posedge clk) begin : model
    item_t       it;
    item_t       w;
    bit          have;
    bit          fromLoad;
    logic [28:0] e;
    w        = '{value: 16'h0, src: 4'h0, rg: 4'h0, nowb: 1'b0};
    have     = 1'b0;
    fromLoad = 1'b0;
    if (rst) begin
      fq.delete();
      lq.delete();
      m_rr   = 1'b0;
      m_busy = 0;
      m_conf = 0;
    end else begin
      if (f_valid && fq.size() == 0) begin
        it = '{value: f_value, src: f_src, rg: f_reg, nowb: f_nowb};
        fq.push_back(it);
      end
      if (l_valid && lq.size() == 0) begin
        it = '{value: l_value, src: l_src, rg: l_reg, nowb: 1'b0};
        lq.push_back(it);
      end
      if (fq.size() > 0 && lq.size() > 0) begin
        have     = 1'b1;
        fromLoad = m_rr;
        m_rr     = !m_rr;
        if (m_conf < CMAX) m_conf++;
      end else if (fq.size() > 0) begin
        have = 1'b1;
      end else if (lq.size() > 0) begin
        have     = 1'b1;
        fromLoad = 1'b1;
      end
      if (have) begin
        w      = fromLoad ? lq.pop_front() : fq.pop_front();
        m_busy = (m_busy + 1) % (CMAX + 1);
      end
    end
    e = {have, (fq.size() == 0), (lq.size() == 0),
         (fromLoad ? 1'b1 : !w.nowb), fromLoad, w.value, w.src, w.rg};
    exp_q.push_back(e);
    cnt_q.push_back({m_busy[CW-1:0], m_conf[CW-1:0]});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [28:0]     e;
    logic [2*CW-1:0] c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      check("sb_cdb_valid", {31'b0, cdb_valid}, {31'b0, e[28]});
      check("sb_f_ready",   {31'b0, f_ready},   {31'b0, e[27]});
      check("sb_l_ready",   {31'b0, l_ready},   {31'b0, e[26]});
      if (e[28]) begin
        check("sb_cdb_wb",        {31'b0, cdb_wb},        {31'b0, e[25]});
        check("sb_cdb_from_load", {31'b0, cdb_from_load}, {31'b0, e[24]});
        check("sb_cdb_payload",   {8'b0, cdb_value, cdb_src, cdb_reg}, {8'b0, e[23:0]});
      end
      check("sb_busy_cnt",     {{(32-CW){1'b0}}, busy_cnt},     {{(32-CW){1'b0}}, c[2*CW-1:CW]});
      check("sb_conflict_cnt", {{(32-CW){1'b0}}, conflict_cnt}, {{(32-CW){1'b0}}, c[CW-1:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_f(input logic [15:0] v, input logic [3:0] s, input logic [3:0] r, input logic nw);
    f_valid = 1'b1; f_value = v; f_src = s; f_reg = r; f_nowb = nw;
  endtask

  task automatic set_l(input logic [15:0] v, input logic [3:0] s, input logic [3:0] r);
    l_valid = 1'b1; l_value = v; l_src = s; l_reg = r;
  endtask

  // Random producers that obey the handshake: a result is held until the
  // posedge that accepted it (or a reset dropped it).
  task automatic run_drive(input int cycles, input int pf, input int pl, input bit randRst);
    bit fSeen, lSeen, rstSeen;
    fSeen   = f_ready;
    lSeen   = l_ready;
    rstSeen = rst;
    for (int i = 0; i < cycles; i++) begin
      if (!f_valid || fSeen || rstSeen) begin
        if ($urandom_range(0, 99) < pf)
          set_f(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        else
          f_valid = 1'b0;
      end
      if (!l_valid || lSeen || rstSeen) begin
        if ($urandom_range(0, 99) < pl)
          set_l(16'($urandom_range(0, 65535)), 4'($urandom_range(2, 3)),
                4'($urandom_range(0, 15)));
        else
          l_valid = 1'b0;
      end
      rst     = randRst && ($urandom_range(0, 249) == 0);
      fSeen   = f_ready;
      lSeen   = l_ready;
      rstSeen = rst;
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset with both producers asserting valid
    rst = 1'b1;
    set_f(16'hAAAA, 4'd1, 4'd1, 1'b0);
    set_l(16'h5555, 4'd2, 4'd2);
    repeat (2) @(negedge clk);
    check("rst_cdb_valid",   {31'b0, cdb_valid}, 32'd0);
    check("rst_f_ready",     {31'b0, f_ready}, 32'd1);
    check("rst_l_ready",     {31'b0, l_ready}, 32'd1);
    check("rst_busy_cnt",    {26'b0, busy_cnt}, 32'd0);
    check("rst_conflict",    {26'b0, conflict_cnt}, 32'd0);
    check("rst_payload",     {8'b0, cdb_value, cdb_src, cdb_reg}, 32'd0);
    check("rst_wb_fromload", {30'b0, cdb_wb, cdb_from_load}, 32'd0);

    // solo adder
    rst = 1'b0;
    l_valid = 1'b0;
    set_f(16'h0012, 4'd1, 4'd5, 1'b0);
    @(negedge clk);
    check("solo_valid",     {31'b0, cdb_valid}, 32'd1);
    check("solo_value",     {16'b0, cdb_value}, 32'h0012);
    check("solo_src_reg",   {24'b0, cdb_src, cdb_reg}, 32'h15);
    check("solo_wb",        {31'b0, cdb_wb}, 32'd1);
    check("solo_from_load", {31'b0, cdb_from_load}, 32'd0);
    check("solo_busy_cnt",  {26'b0, busy_cnt}, 32'd1);

    // collision with adder favoured
    set_f(16'h0003, 4'd0, 4'd2, 1'b0);
    set_l(16'hBEEF, 4'd2, 4'd7);
    @(negedge clk);
    f_valid = 1'b0;
    l_valid = 1'b0;
    check("coll_first_value", {16'b0, cdb_value}, 32'h0003);
    check("coll_first_adder", {31'b0, cdb_from_load}, 32'd0);
    check("coll_l_ready",     {31'b0, l_ready}, 32'd0);
    check("coll_conflict",    {26'b0, conflict_cnt}, 32'd1);
    @(negedge clk);
    check("coll_second_valid", {31'b0, cdb_valid}, 32'd1);
    check("coll_second_value", {16'b0, cdb_value}, 32'hBEEF);
    check("coll_second_tags",  {24'b0, cdb_src, cdb_reg}, 32'h27);
    check("coll_second_load",  {31'b0, cdb_from_load}, 32'd1);
    check("coll_l_ready_back", {31'b0, l_ready}, 32'd1);

    // jeq outcome: broadcast without writeback
    set_f(16'h0004, 4'd1, 4'd0, 1'b1);
    @(negedge clk);
    check("jeq_valid", {31'b0, cdb_valid}, 32'd1);
    check("jeq_wb",    {31'b0, cdb_wb}, 32'd0);
    check("jeq_value", {16'b0, cdb_value}, 32'h0004);

    // second collision: pointer now favours the loader
    set_f(16'h0005, 4'd1, 4'd1, 1'b0);
    set_l(16'h0006, 4'd3, 4'd4);
    @(negedge clk);
    f_valid = 1'b0;
    l_valid = 1'b0;
    check("rr_loader_wins", {31'b0, cdb_from_load}, 32'd1);
    check("rr_f_ready",     {31'b0, f_ready}, 32'd0);
    @(negedge clk);
    check("rr_adder_next",  {16'b0, cdb_value}, 32'h0005);

    // reset while a loader result sits in its buffer
    set_f(16'h1111, 4'd0, 4'd3, 1'b0);
    set_l(16'hDEAD, 4'd3, 4'd9);
    @(negedge clk);
    f_valid = 1'b0;
    l_valid = 1'b0;
    check("midrst_adder_on_bus", {16'b0, cdb_value}, 32'h1111);
    check("midrst_l_buffered",   {31'b0, l_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid",   {31'b0, cdb_valid}, 32'd0);
    check("midrst_l_ready", {31'b0, l_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ghost", {31'b0, cdb_valid}, 32'd0);
    end

    // sustained contention, then long random traffic with occasional resets
    run_drive(6, 100, 100, 1'b0);
    run_drive(800, 100, 100, 1'b0);
    run_drive(3000, 60, 55, 1'b1);
    f_valid = 1'b0;
    l_valid = 1'b0;
    rst     = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_idle", {31'b0, cdb_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
